// File: rtl/interrupt_sequencer.sv
// Latches NMI/IRQ/BRK, picks one at each instruction boundary and holds type, B flag and vector for the service sequence.
// Latency: NMI pin to int_req 2 edges, IRQ pin to int_req 1 edge after sampling; capture valid the edge after sync.
// No backpressure: sync, vec_fetch and svc_done are accepted on the cycle they are high.
module interrupt_sequencer (
    input  logic       clk,
    input  logic       rst,
    input  logic       nmi_n,
    input  logic       irq_n,
    input  logic       sync,
    input  logic       brk_op,
    input  logic       i_flag,
    input  logic       vec_fetch,
    input  logic       svc_done,
    output logic       int_req,
    output logic       in_service,
    output logic [3:0] int_type,
    output logic [7:0] vector_lo,
    output logic       b_flag,
    output logic       force_brk
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVICE = 2'd1,
        VECTOR  = 2'd2
    } state_t;

    localparam logic [3:0] TYPE_RST = 4'b0001;
    localparam logic [3:0] TYPE_NMI = 4'b0010;
    localparam logic [3:0] TYPE_IRQ = 4'b0100;
    localparam logic [3:0] TYPE_BRK = 4'b1000;

    localparam logic [7:0] VEC_RST = 8'hFC;
    localparam logic [7:0] VEC_NMI = 8'hFA;
    localparam logic [7:0] VEC_IRQ = 8'hFE;

    state_t     state, state_nxt;
    logic       nmi_s1, nmi_s2, nmi_prev;
    logic       irq_s1, irq_s2;
    logic       nmi_latch, nmi_latch_nxt;
    logic       nmi_edge, nmi_clr, irq_req;
    logic [3:0] int_type_nxt;
    logic [7:0] vector_lo_nxt;
    logic       b_flag_nxt, force_brk_nxt;

    assign nmi_edge   = nmi_prev & ~nmi_s2;
    assign irq_req    = ~irq_s2 & ~i_flag;
    assign int_req    = (state == IDLE) & (nmi_latch | irq_req);
    assign in_service = (state != IDLE);

    always_comb begin
        state_nxt     = state;
        int_type_nxt  = int_type;
        vector_lo_nxt = vector_lo;
        b_flag_nxt    = b_flag;
        force_brk_nxt = force_brk;
        nmi_clr       = 1'b0;

        unique case (state)
            IDLE: begin
                if (sync) begin
                    if (nmi_latch) begin
                        state_nxt     = SERVICE;
                        int_type_nxt  = TYPE_NMI;
                        vector_lo_nxt = VEC_NMI;
                        force_brk_nxt = 1'b1;
                        b_flag_nxt    = 1'b0;
                        nmi_clr       = 1'b1;
                    end else if (irq_req) begin
                        state_nxt     = SERVICE;
                        int_type_nxt  = TYPE_IRQ;
                        vector_lo_nxt = VEC_IRQ;
                        force_brk_nxt = 1'b1;
                        b_flag_nxt    = 1'b0;
                    end else if (brk_op) begin
                        state_nxt     = SERVICE;
                        int_type_nxt  = TYPE_BRK;
                        vector_lo_nxt = VEC_IRQ;
                        force_brk_nxt = 1'b0;
                        b_flag_nxt    = 1'b1;
                    end
                end
            end
            SERVICE: begin
                // svc_done takes priority so a pending NMI stays latched for the next boundary
                if (svc_done) begin
                    state_nxt     = IDLE;
                    force_brk_nxt = 1'b0;
                    b_flag_nxt    = 1'b0;
                end else begin
                    if (nmi_latch && (int_type == TYPE_IRQ || int_type == TYPE_BRK)) begin
                        int_type_nxt  = TYPE_NMI;
                        vector_lo_nxt = VEC_NMI;
                        nmi_clr       = 1'b1;
                    end
                    if (vec_fetch) begin
                        state_nxt = VECTOR;
                    end
                end
            end
            VECTOR: begin
                if (svc_done) begin
                    state_nxt     = IDLE;
                    force_brk_nxt = 1'b0;
                    b_flag_nxt    = 1'b0;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // A fresh edge beats a capture-clear so back-to-back NMIs are not lost
        if (nmi_edge) begin
            nmi_latch_nxt = 1'b1;
        end else if (nmi_clr) begin
            nmi_latch_nxt = 1'b0;
        end else begin
            nmi_latch_nxt = nmi_latch;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= SERVICE;
            int_type  <= TYPE_RST;
            vector_lo <= VEC_RST;
            b_flag    <= 1'b0;
            force_brk <= 1'b1;
            nmi_latch <= 1'b0;
            nmi_s1    <= 1'b1;
            nmi_s2    <= 1'b1;
            nmi_prev  <= 1'b1;
            irq_s1    <= 1'b1;
            irq_s2    <= 1'b1;
        end else begin
            state     <= state_nxt;
            int_type  <= int_type_nxt;
            vector_lo <= vector_lo_nxt;
            b_flag    <= b_flag_nxt;
            force_brk <= force_brk_nxt;
            nmi_latch <= nmi_latch_nxt;
            nmi_s1    <= nmi_n;
            nmi_s2    <= nmi_s1;
            nmi_prev  <= nmi_s2;
            irq_s1    <= irq_n;
            irq_s2    <= irq_s1;
        end
    end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Scoreboard bench: a pin-history reference model predicts the outputs after every edge; a monitor compares on the opposite edge.
module tb_interrupt_sequencer;

    logic       clk = 1'b0;
    logic       rst, nmi_n, irq_n, sync, brk_op, i_flag, vec_fetch, svc_done;
    logic       int_req, in_service, b_flag, force_brk;
    logic [3:0] int_type;
    logic [7:0] vector_lo;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    interrupt_sequencer dut (
        .clk(clk), .rst(rst), .nmi_n(nmi_n), .irq_n(irq_n), .sync(sync),
        .brk_op(brk_op), .i_flag(i_flag), .vec_fetch(vec_fetch), .svc_done(svc_done),
        .int_req(int_req), .in_service(in_service), .int_type(int_type),
        .vector_lo(vector_lo), .b_flag(b_flag), .force_brk(force_brk)
    );

    typedef struct {
        logic [3:0] it;
        logic [7:0] vl;
        bit         b;
        bit         fb;
        bit         busy;
        bit         latch;
        bit         irq_low;
    } exp_t;

    exp_t sb[$];

    // Reference model: mode 0 idle, 1 running before vector lock, 2 vector locked.
    int         m_mode;
    logic [3:0] m_type;
    logic [7:0] m_vec;
    bit         m_b, m_fb, m_latch, m_seen;
    bit         nh[3];  // nmi pin history, [0] = most recent sample
    bit         ih[3];

    function automatic logic [7:0] vec_of(input logic [3:0] t);
        if (t == 4'b0001) return 8'hFC;
        if (t == 4'b0010) return 8'hFA;
        return 8'hFE;
    endfunction

    always @(posedge clk) begin
        bit got_edge, irq_ok, clr;
        exp_t e;
        if (rst) begin
            m_mode = 1; m_type = 4'b0001; m_vec = 8'hFC; m_b = 0; m_fb = 1;
            m_latch = 0; m_seen = 1;
            for (int i = 0; i < 3; i++) begin nh[i] = 1; ih[i] = 1; end
        end else if (m_seen) begin
            got_edge = nh[2] & ~nh[1];
            irq_ok   = ~ih[1] & ~i_flag;
            clr      = 0;
            if (m_mode == 0) begin
                if (sync && (m_latch || irq_ok || brk_op)) begin
                    m_mode = 1;
                    if (m_latch)     begin m_type = 4'b0010; clr = 1; end
                    else if (irq_ok) m_type = 4'b0100;
                    else             m_type = 4'b1000;
                    m_vec = vec_of(m_type);
                    m_b   = (m_type == 4'b1000);
                    m_fb  = !m_b;
                end
            end else if (svc_done) begin
                m_mode = 0; m_b = 0; m_fb = 0;
            end else if (m_mode == 1) begin
                if (m_latch && (m_type == 4'b0100 || m_type == 4'b1000)) begin
                    m_type = 4'b0010; m_vec = vec_of(m_type); clr = 1;
                end
                if (vec_fetch) m_mode = 2;
            end
            if (got_edge) m_latch = 1;
            else if (clr) m_latch = 0;
            nh[2] = nh[1]; nh[1] = nh[0]; nh[0] = nmi_n;
            ih[2] = ih[1]; ih[1] = ih[0]; ih[0] = irq_n;
        end
        if (m_seen) begin
            e.it = m_type; e.vl = m_vec; e.b = m_b; e.fb = m_fb;
            e.busy = (m_mode != 0); e.latch = m_latch; e.irq_low = ~ih[1];
            sb.push_back(e);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        bit   exp_req;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            exp_req = !e.busy && (e.latch || (e.irq_low && !i_flag));
            total++;
            if (int_type !== e.it || vector_lo !== e.vl || b_flag !== e.b ||
                force_brk !== e.fb || in_service !== e.busy || int_req !== exp_req) begin
                bad++;
                $display("FAIL outputs t=%0t got type=%b vec=%h b=%b fb=%b svc=%b req=%b want type=%b vec=%h b=%b fb=%b svc=%b req=%b",
                         $time, int_type, vector_lo, b_flag, force_brk, in_service, int_req,
                         e.it, e.vl, e.b, e.fb, e.busy, exp_req);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_sync(input bit brk);
        sync = 1; brk_op = brk; step(1); sync = 0; brk_op = 0;
    endtask

    task automatic pulse_vec();
        vec_fetch = 1; step(1); vec_fetch = 0;
    endtask

    task automatic pulse_done();
        svc_done = 1; step(1); svc_done = 0;
    endtask

    task automatic nmi_pulse(input int len);
        nmi_n = 0; step(len); nmi_n = 1;
    endtask

    initial begin
        rst = 1; nmi_n = 1; irq_n = 1; sync = 0; brk_op = 0; i_flag = 0;
        vec_fetch = 0; svc_done = 0;

        // reset sequence
        step(3); rst = 0; step(6); pulse_done(); step(3);

        // priority NMI > IRQ > BRK, then IRQ after service
        nmi_pulse(3); irq_n = 0; step(3);
        pulse_sync(1); step(2); pulse_vec(); step(2); pulse_done();
        pulse_sync(0); step(1); pulse_vec(); step(1); pulse_done(); irq_n = 1; step(3);

        // IRQ masked by I flag
        i_flag = 1; irq_n = 0; step(2);
        repeat (5) begin pulse_sync(0); step(1); end
        i_flag = 0; step(1); pulse_sync(0); step(1); pulse_vec(); pulse_done();
        irq_n = 1; step(3);

        // BRK hijacked by NMI
        pulse_sync(1); step(1); nmi_pulse(2); step(4); pulse_vec(); step(1); pulse_done(); step(3);

        // late NMI after vector lock of an IRQ
        irq_n = 0; step(3); pulse_sync(0); irq_n = 1; pulse_vec();
        nmi_pulse(2); step(5); pulse_done(); pulse_sync(0); step(1); pulse_vec(); pulse_done(); step(3);

        // reset in the middle of an IRQ with an NMI pending
        irq_n = 0; step(3); pulse_sync(0); irq_n = 1; pulse_vec();
        nmi_pulse(2); step(4); rst = 1; step(1); rst = 0; step(2);
        pulse_done(); pulse_sync(0); step(3);

        // NMI held low across reset
        nmi_n = 0; rst = 1; step(2); rst = 0; step(5); pulse_done(); step(2);
        pulse_sync(0); nmi_n = 1; step(2); pulse_done(); step(2);

        // randomized traffic
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(15) == 0) nmi_n = ~nmi_n;
            if ($urandom_range(11) == 0) irq_n = ~irq_n;
            if ($urandom_range(9) == 0)  i_flag = ~i_flag;
            sync      = ($urandom_range(2) == 0);
            brk_op    = ($urandom_range(3) == 0);
            vec_fetch = ($urandom_range(5) == 0);
            svc_done  = ($urandom_range(7) == 0);
            rst       = ($urandom_range(199) == 0);
            step(1);
        end
        rst = 0; sync = 0; vec_fetch = 0; svc_done = 0;
        step(3);
        @(negedge clk); #1;

        total++;
        if (sb.size() != 0 || total < 12) begin
            bad++;
            $display("FAIL drain got pending=%0d checks=%0d want pending=0 checks>=12", sb.size(), total);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
